// File: rtl/mcs4_pkg.sv
// ----------------------------------------------------------------------------
// mcs4_pkg
// Shared constants for the MCS-4 instruction cycle sequencer.
//   - PH_A1 .. PH_X3 : subcycle index within the 8-subcycle instruction cycle
//   - OPR_*          : first-word OPR opcode values
//   - is_double_cycle: 1 when the first instruction word needs a second cycle
// ----------------------------------------------------------------------------
package mcs4_pkg;

   localparam logic [2:0] PH_A1 = 3'd0;
   localparam logic [2:0] PH_A2 = 3'd1;
   localparam logic [2:0] PH_A3 = 3'd2;
   localparam logic [2:0] PH_M1 = 3'd3;
   localparam logic [2:0] PH_M2 = 3'd4;
   localparam logic [2:0] PH_X1 = 3'd5;
   localparam logic [2:0] PH_X2 = 3'd6;
   localparam logic [2:0] PH_X3 = 3'd7;

   localparam logic [3:0] OPR_NOP     = 4'h0;
   localparam logic [3:0] OPR_JCN     = 4'h1;
   localparam logic [3:0] OPR_FIM_SRC = 4'h2;
   localparam logic [3:0] OPR_FIN_JIN = 4'h3;
   localparam logic [3:0] OPR_JUN     = 4'h4;
   localparam logic [3:0] OPR_JMS     = 4'h5;
   localparam logic [3:0] OPR_INC     = 4'h6;
   localparam logic [3:0] OPR_ISZ     = 4'h7;
   localparam logic [3:0] OPR_ADD     = 4'h8;
   localparam logic [3:0] OPR_SUB     = 4'h9;
   localparam logic [3:0] OPR_LD      = 4'hA;
   localparam logic [3:0] OPR_XCH     = 4'hB;
   localparam logic [3:0] OPR_BBL     = 4'hC;
   localparam logic [3:0] OPR_LDM     = 4'hD;
   localparam logic [3:0] OPR_IO      = 4'hE;
   localparam logic [3:0] OPR_ACC     = 4'hF;

   // FIM and FIN share their OPR with SRC and JIN; opa[0] tells them apart.
   function automatic logic is_double_cycle(input logic [3:0] opr,
                                            input logic [3:0] opa);
      case (opr)
         OPR_JCN, OPR_JUN, OPR_JMS, OPR_ISZ: return 1'b1;
         OPR_FIM_SRC, OPR_FIN_JIN:           return (opa & 4'h1) == 4'h0;
         default:                            return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/subcycle_timer.sv
// ----------------------------------------------------------------------------
// subcycle_timer
// Self-timed generator of the 8-subcycle instruction timing (A1..X3).
// Ports:
//   sysclk     in   system clock, rising edge
//   poc        in   power-on clear, asynchronous, active-high
//   park_req   in   park in A1 at the coming wrap (only meaningful at X3 end)
//   hold       in   keeps the timer parked while high
//   phase      out  one-hot current subcycle (bit 0 = A1)
//   phase_last out  registered, high on the final tick of each subcycle
//   sync       out  registered, high for all of subcycle SYNC_PHASE
//   parked     out  timer is parked in A1 with the tick frozen at 0
// ----------------------------------------------------------------------------
module subcycle_timer
   import mcs4_pkg::*;
#(
   parameter int TICKS_PER_PHASE = 2,
   parameter int SYNC_PHASE      = 7
) (
   input  logic       sysclk,
   input  logic       poc,
   input  logic       park_req,
   input  logic       hold,
   output logic [7:0] phase,
   output logic       phase_last,
   output logic       sync,
   output logic       parked
);

   localparam int         TW       = $clog2(TICKS_PER_PHASE);
   localparam logic [7:0] PHASE_A1 = 8'd1 << PH_A1;

   if (TICKS_PER_PHASE < 2) begin : g_bad_ticks
      $error("TICKS_PER_PHASE must be at least 2");
   end
   if (SYNC_PHASE < 0 || SYNC_PHASE > 7) begin : g_bad_sync
      $error("SYNC_PHASE must be 0..7");
   end

   logic [TW-1:0] tick;
   logic [TW-1:0] tick_nxt;
   logic          tick_wrap;
   logic [7:0]    phase_nxt;

   always_comb begin
      tick_wrap = (tick == TW'(TICKS_PER_PHASE - 1));
      tick_nxt  = tick_wrap ? '0 : tick + TW'(1);
      phase_nxt = tick_wrap ? {phase[6:0], phase[7]} : phase;
   end

   // phase_last and sync are computed from the next state so that they line
   // up with the tick/phase they describe rather than lagging by one cycle.
   always_ff @(posedge sysclk or posedge poc) begin
      if (poc) begin
         tick       <= '0;
         phase      <= PHASE_A1;
         phase_last <= 1'b0;
         sync       <= 1'b0;
         parked     <= 1'b0;
      end else if (parked) begin
         // Tick stays 0 in A1; the release edge itself does not advance.
         if (!hold) begin
            parked <= 1'b0;
            sync   <= phase[SYNC_PHASE];
         end
      end else if (park_req) begin
         tick       <= '0;
         phase      <= PHASE_A1;
         phase_last <= 1'b0;
         sync       <= 1'b0;
         parked     <= 1'b1;
      end else begin
         tick       <= tick_nxt;
         phase      <= phase_nxt;
         phase_last <= (tick_nxt == TW'(TICKS_PER_PHASE - 1));
         sync       <= phase_nxt[SYNC_PHASE];
      end
   end

endmodule

// File: rtl/instr_cycle_sequencer.sv
// ----------------------------------------------------------------------------
// instr_cycle_sequencer
// Self-timed 4004-style instruction cycle sequencer: generates A1..X3 timing,
// latches OPR/OPA and the second word of double-cycle instructions, evaluates
// the JCN/ISZ/JUN/JMS jump condition and signals instruction completion.
// Optional build macro SEQ_HOLD_EN adds the hold/hold_ack park handshake.
// Ports:
//   sysclk     in   system clock, rising edge
//   poc        in   power-on clear, asynchronous, active-high
//   data_in    in   common data bus (read side)
//   test_n     in   conditioned TEST pin, active-low
//   acc_zero   in   ACC == 0 from the ALU
//   carry      in   CY from the ALU
//   isz_zero   in   ISZ increment result == 0, from SP
//   hold       in   (SEQ_HOLD_EN) park request, sampled at instruction end
//   hold_ack   out  (SEQ_HOLD_EN) sequencer parked in A1
//   phase      out  one-hot subcycle, bit 0 = A1 .. bit 7 = X3
//   phase_last out  final tick of the current subcycle
//   sync       out  high for all of subcycle SYNC_PHASE
//   opr, opa   out  latched first instruction word
//   operand    out  second instruction word {OPR2, OPA2}
//   dc         out  second cycle of a double-cycle instruction in progress
//   jump_taken out  jump condition of the current instruction
//   instr_done out  one-sysclk pulse after the instruction's last X3
// ----------------------------------------------------------------------------
module instr_cycle_sequencer
   import mcs4_pkg::*;
#(
   parameter int TICKS_PER_PHASE = 2,
   parameter int SYNC_PHASE      = 7,
   parameter int DATA_W          = 4
) (
   input  logic                sysclk,
   input  logic                poc,
   input  logic [DATA_W-1:0]   data_in,
   input  logic                test_n,
   input  logic                acc_zero,
   input  logic                carry,
   input  logic                isz_zero,
`ifdef SEQ_HOLD_EN
   input  logic                hold,
   output logic                hold_ack,
`endif
   output logic [7:0]          phase,
   output logic                phase_last,
   output logic                sync,
   output logic [DATA_W-1:0]   opr,
   output logic [DATA_W-1:0]   opa,
   output logic [2*DATA_W-1:0] operand,
   output logic                dc,
   output logic                jump_taken,
   output logic                instr_done
);

   if (DATA_W != 4) begin : g_bad_width
      $error("DATA_W must be 4");
   end

   function automatic logic eval_jump(input logic [3:0] op_r,
                                      input logic [3:0] op_a,
                                      input logic       az,
                                      input logic       cy,
                                      input logic       tn,
                                      input logic       iz);
      case (op_r)
         OPR_JCN:          return ((op_a[2] & az) | (op_a[1] & cy) | (op_a[0] & ~tn)) ^ op_a[3];
         OPR_ISZ:          return ~iz;
         OPR_JUN, OPR_JMS: return 1'b1;
         default:          return 1'b0;
      endcase
   endfunction

   logic hold_int;
   logic parked;
   logic cap_m1;
   logic cap_m2;
   logic last_x3;
   logic first_dbl;
   logic completes;
   logic park_req;

`ifdef SEQ_HOLD_EN
   assign hold_int = hold;
   assign hold_ack = parked;
`else
   assign hold_int = 1'b0;
`endif

   always_comb begin
      cap_m1    = phase[PH_M1] & phase_last;
      cap_m2    = phase[PH_M2] & phase_last;
      last_x3   = phase[PH_X3] & phase_last & ~parked;
      first_dbl = is_double_cycle(opr, opa);
      completes = last_x3 & (dc | ~first_dbl);
      // A hold seen during a first cycle that sets dc waits for cycle two.
      park_req  = completes & hold_int;
   end

   subcycle_timer #(
      .TICKS_PER_PHASE (TICKS_PER_PHASE),
      .SYNC_PHASE      (SYNC_PHASE)
   ) u_timer (
      .sysclk     (sysclk),
      .poc        (poc),
      .park_req   (park_req),
      .hold       (hold_int),
      .phase      (phase),
      .phase_last (phase_last),
      .sync       (sync),
      .parked     (parked)
   );

   always_ff @(posedge sysclk or posedge poc) begin
      if (poc) begin
         opr        <= '0;
         opa        <= '0;
         operand    <= '0;
         dc         <= 1'b0;
         jump_taken <= 1'b0;
         instr_done <= 1'b0;
      end else begin
         instr_done <= 1'b0;

         // opr keeps the first word during cycle two, so FIN is still
         // recognisable and its fetched data never lands in operand.
         if (cap_m1) begin
            if (!dc)                    opr <= data_in;
            else if (opr != OPR_FIN_JIN) operand[2*DATA_W-1:DATA_W] <= data_in;
         end
         if (cap_m2) begin
            if (!dc)                    opa <= data_in;
            else if (opr != OPR_FIN_JIN) operand[DATA_W-1:0] <= data_in;
         end

         if (last_x3) begin
            if (dc) begin
               dc         <= 1'b0;
               instr_done <= 1'b1;
            end else begin
               dc         <= first_dbl;
               instr_done <= ~first_dbl;
               jump_taken <= eval_jump(opr, opa, acc_zero, carry, test_n, isz_zero);
            end
         end
      end
   end

endmodule

// File: tb/tb_instr_cycle_sequencer.sv
// ----------------------------------------------------------------------------
// tb_instr_cycle_sequencer
// Directed and randomized instruction streams for instr_cycle_sequencer,
// checked against an instruction-level reference model. Define SEQ_HOLD_EN
// to exercise the hold/hold_ack park handshake as well.
// ----------------------------------------------------------------------------
module tb_instr_cycle_sequencer;

   localparam int T   = 2;
   localparam int SP  = 7;
   localparam int CYC = 8 * T;

   logic       sysclk = 1'b0;
   logic       poc;
   logic [3:0] data_in;
   logic       test_n, acc_zero, carry, isz_zero;
   logic       hold;
   logic       hold_ack;
   logic [7:0] phase;
   logic       phase_last, sync;
   logic [3:0] opr, opa;
   logic [7:0] operand;
   logic       dc, jump_taken, instr_done;

   int vectors     = 0;
   int miscompares = 0;
   int pos         = 0;

   logic [3:0] m_opr, m_opa;
   logic [7:0] m_operand;
   logic       m_dc, m_jt, m_done;

   always #5 sysclk = ~sysclk;

`ifndef SEQ_HOLD_EN
   assign hold_ack = 1'b0;
`endif

   instr_cycle_sequencer #(
      .TICKS_PER_PHASE (T),
      .SYNC_PHASE      (SP),
      .DATA_W          (4)
   ) dut (
      .sysclk     (sysclk),
      .poc        (poc),
      .data_in    (data_in),
      .test_n     (test_n),
      .acc_zero   (acc_zero),
      .carry      (carry),
      .isz_zero   (isz_zero),
`ifdef SEQ_HOLD_EN
      .hold       (hold),
      .hold_ack   (hold_ack),
`endif
      .phase      (phase),
      .phase_last (phase_last),
      .sync       (sync),
      .opr        (opr),
      .opa        (opa),
      .operand    (operand),
      .dc         (dc),
      .jump_taken (jump_taken),
      .instr_done (instr_done)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference rules, written from the instruction set description.
   function automatic logic ref_double(input logic [3:0] r, input logic [3:0] a);
      if (r == 4'h1 || r == 4'h4 || r == 4'h5 || r == 4'h7) return 1'b1;
      if ((r == 4'h2 || r == 4'h3) && a[0] == 1'b0)         return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic ref_jump(input logic [3:0] r, input logic [3:0] a,
                                     input logic az, input logic cy,
                                     input logic tn, input logic iz);
      logic hit;
      if (r == 4'h1) begin
         hit = (a[2] && az) || (a[1] && cy) || (a[0] && !tn);
         return a[3] ? !hit : hit;
      end
      if (r == 4'h7)               return !iz;
      if (r == 4'h4 || r == 4'h5) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_clear();
      m_opr = 4'h0; m_opa = 4'h0; m_operand = 8'h00;
      m_dc = 1'b0; m_jt = 1'b0; m_done = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_phase"},   16'(phase),      16'h0001);
      chk({tag, "_plast"},   16'(phase_last), 16'h0);
      chk({tag, "_sync"},    16'(sync),       16'h0);
      chk({tag, "_opr"},     16'(opr),        16'h0);
      chk({tag, "_opa"},     16'(opa),        16'h0);
      chk({tag, "_operand"}, 16'(operand),    16'h0);
      chk({tag, "_dc"},      16'(dc),         16'h0);
      chk({tag, "_jump"},    16'(jump_taken), 16'h0);
      chk({tag, "_done"},    16'(instr_done), 16'h0);
      chk({tag, "_hack"},    16'(hold_ack),   16'h0);
   endtask

   // One sysclk: check outputs for the current position, drive inputs for
   // the next rising edge. Words and conditions are only valid on their
   // sampling ticks; everything else is random noise.
   task automatic step(input logic [3:0] w_r, input logic [3:0] w_a,
                       input logic c_az, input logic c_cy, input logic c_tn,
                       input logic c_iz, input logic c_h);
      int pc, sub, tk;
      logic last;
      pc   = pos % CYC;
      sub  = pc / T;
      tk   = pc % T;
      last = (tk == T - 1);
      chk("phase",      16'(8'd1 << sub),  16'(phase) == 16'(8'd1 << sub) ? 16'(phase) : 16'(phase));
      chk("phase_last", 16'(phase_last),   16'(last));
      chk("sync",       16'(sync),         16'(sub == SP));
      chk("instr_done", 16'(instr_done),   16'(pc == 0 && m_done));
      chk("hold_ack",   16'(hold_ack),     16'h0);
      if (pc == 0) begin
         chk("opr",        16'(opr),        16'(m_opr));
         chk("opa",        16'(opa),        16'(m_opa));
         chk("operand",    16'(operand),    16'(m_operand));
         chk("dc",         16'(dc),         16'(m_dc));
         chk("jump_taken", 16'(jump_taken), 16'(m_jt));
      end
      data_in = (last && sub == 3) ? w_r : (last && sub == 4) ? w_a : 4'($urandom);
      if (last && sub == 7) begin
         acc_zero = c_az; carry = c_cy; test_n = c_tn; isz_zero = c_iz; hold = c_h;
      end else begin
         acc_zero = 1'($urandom); carry = 1'($urandom);
         test_n = 1'($urandom); isz_zero = 1'($urandom); hold = 1'($urandom);
      end
      @(negedge sysclk);
      pos++;
   endtask

`ifdef SEQ_HOLD_EN
   task automatic park_seq();
      for (int i = 0; i < 3; i++) begin
         chk("park_hack",  16'(hold_ack),   16'h1);
         chk("park_phase", 16'(phase),      16'h0001);
         chk("park_plast", 16'(phase_last), 16'h0);
         chk("park_sync",  16'(sync),       16'h0);
         chk("park_done",  16'(instr_done), 16'(i == 0));
         data_in = 4'($urandom); hold = 1'b1;
         @(negedge sysclk);
      end
      hold = 1'b0;
      @(negedge sysclk);
      chk("unpark_hack",  16'(hold_ack), 16'h0);
      chk("unpark_phase", 16'(phase),    16'h0001);
      m_done = 1'b0;
   endtask
`endif

   task automatic mcycle(input logic [3:0] w_r, input logic [3:0] w_a,
                         input logic az, input logic cy, input logic tn,
                         input logic iz, input logic h);
      for (int i = 0; i < CYC; i++) step(w_r, w_a, az, cy, tn, iz, h);
      if (!m_dc) begin
         m_opr  = w_r;
         m_opa  = w_a;
         m_jt   = ref_jump(w_r, w_a, az, cy, tn, iz);
         m_dc   = ref_double(w_r, w_a);
         m_done = !m_dc;
      end else begin
         if (m_opr != 4'h3) m_operand = {w_r, w_a};
         m_dc   = 1'b0;
         m_done = 1'b1;
      end
`ifdef SEQ_HOLD_EN
      if (m_done && h) park_seq();
`endif
   endtask

   task automatic instr(input logic [3:0] r, input logic [3:0] a,
                        input logic [3:0] r2, input logic [3:0] a2,
                        input logic az, input logic cy, input logic tn,
                        input logic iz, input logic h);
      mcycle(r, a, az, cy, tn, iz, h);
      if (m_dc) mcycle(r2, a2, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), h);
   endtask

   initial begin
      poc = 1'b0; data_in = 4'h0; test_n = 1'b1; acc_zero = 1'b0;
      carry = 1'b0; isz_zero = 1'b0; hold = 1'b0;
      model_clear();
      #1 poc = 1'b1;
      @(negedge sysclk);
      @(negedge sysclk);
      check_reset_outputs("reset");
      poc = 1'b0;
      pos = 0;

      // LDM 5
      instr(4'hD, 4'h5, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      // JCN on ACC==0, taken; second word 0x3A
      instr(4'h1, 4'h4, 4'h3, 4'hA, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      // JCN inverted, not taken
      instr(4'h1, 4'hC, 4'h5, 4'h6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      // ISZ not zero -> taken, zero -> not taken
      instr(4'h7, 4'h3, 4'h1, 4'h2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      instr(4'h7, 4'h3, 4'h9, 4'h8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      // FIN keeps operand; SRC is single-cycle
      instr(4'h3, 4'h0, 4'hE, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      instr(4'h2, 4'h1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      // FIM, JMS, JCN on TEST low and on carry
      instr(4'h2, 4'h4, 4'h7, 4'hC, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      instr(4'h5, 4'h1, 4'hB, 4'h4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      instr(4'h1, 4'h1, 4'h2, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      instr(4'h1, 4'h2, 4'h6, 4'h1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

      // Hold at the end of a single-cycle and of a double-cycle instruction
      instr(4'hD, 4'h9, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      instr(4'h4, 4'h2, 4'hC, 4'h3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

      for (int n = 0; n < 24; n++) begin
         instr(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
               1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
               ($urandom_range(3, 0) == 0));
      end

      // Power-on clear during M2 of a JUN second cycle
      mcycle(4'h4, 4'h6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      while ((pos % CYC) != 4 * T) step(4'h8, 4'h1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      #2 poc = 1'b1;
      #1 check_reset_outputs("poc_mid");
      @(negedge sysclk);
      check_reset_outputs("poc_hold");
      poc = 1'b0;
      pos = 0;
      model_clear();
      instr(4'hD, 4'h2, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      instr(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      step(4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
